// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE-array address sequencer and its helpers.
package pe_pkg;

  localparam int DIM_W_DEF  = 16;
  localparam int ADDR_W_DEF = 32;

  // Sequencer states; explicit encodings keep waveforms and legacy decoders stable.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PART = 3'd1,
    ST_SEEK = 3'd2,
    ST_WAIT = 3'd3,
    ST_RUN  = 3'd4,
    ST_DONE = 3'd5
  } seq_state_t;

  // One core's job description at the default widths (used by load/control code).
  typedef struct packed {
    logic [DIM_W_DEF-1:0]  m;
    logic [DIM_W_DEF-1:0]  n;
    logic [DIM_W_DEF-1:0]  p;
    logic [ADDR_W_DEF-1:0] left_offset;
    logic [ADDR_W_DEF-1:0] right_offset;
    logic [ADDR_W_DEF-1:0] result_offset;
    logic                  right_transposed;
  } core_cfg_t;

endpackage

// File: rtl/pe_partition.sv
// Splits the M*P output cells across PE_COUNT cores (remainder cells go to the
// lowest core ids) and walks this core's first cell index into (row, col).
module pe_partition #(
  parameter int PE_COUNT = 64,
  parameter int DIM_W    = 16,
  parameter int CORE_W   = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [DIM_W-1:0]     m,
  input  logic [DIM_W-1:0]     p,
  input  logic [CORE_W-1:0]    core_id,
  output logic [2*DIM_W-1:0]   cells,
  output logic [2*DIM_W-1:0]   cell0,
  output logic [DIM_W-1:0]     row,
  output logic [DIM_W-1:0]     col,
  output logic                 seek_done
);

  localparam int TOT_W = 2 * DIM_W;
  localparam int SHIFT = $clog2(PE_COUNT);

  logic [TOT_W-1:0] total;
  logic [TOT_W-1:0] base;
  logic [TOT_W-1:0] rem;
  logic [TOT_W-1:0] core_ext;
  logic             gets_extra;
  logic [TOT_W-1:0] col_q;
  logic [DIM_W-1:0] row_q;

  // Share of cells for this core and the index of its first cell.
  always_comb begin
    core_ext   = TOT_W'(core_id);
    total      = TOT_W'(m) * TOT_W'(p);
    base       = total >> SHIFT;
    rem        = total & TOT_W'(PE_COUNT - 1);
    gets_extra = core_ext < rem;
    cells      = base + (gets_extra ? TOT_W'(1) : '0);
    cell0      = core_ext * base + (gets_extra ? core_ext : rem);
  end

  // Division-free row/col split: subtract P once per cycle until col < P.
  assign seek_done = col_q < TOT_W'(p);
  assign row       = row_q;
  assign col       = col_q[DIM_W-1:0];

  // Seek registers: loaded with cell0, then stepped while still past the row end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (load) begin
      col_q <= cell0;
      row_q <= '0;
    end else if (step && !seek_done) begin
      col_q <= col_q - TOT_W'(p);
      row_q <= row_q + DIM_W'(1);
    end
  end

endmodule

// File: rtl/pe_addr_sequencer.sv
// Per-core operand/result address sequencer for the matrix-multiply PE array.
// Streams (left, right) operand pairs one MAC per beat over valid/ready and
// tags the first and last beat of every output cell with its result address.
module pe_addr_sequencer
  import pe_pkg::*;
#(
  parameter int PE_COUNT = 64,
  parameter int DIM_W    = DIM_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CORE_W   = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              data_ready,
  input  logic [DIM_W-1:0]  M,
  input  logic [DIM_W-1:0]  N,
  input  logic [DIM_W-1:0]  P,
  input  logic [CORE_W-1:0] core_id,
  input  logic              right_transposed,
  input  logic [ADDR_W-1:0] left_offset,
  input  logic [ADDR_W-1:0] right_offset,
  input  logic [ADDR_W-1:0] result_offset,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] left_addr,
  output logic [ADDR_W-1:0] right_addr,
  output logic              first,
  output logic              last,
  output logic [ADDR_W-1:0] result_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TOT_W = 2 * DIM_W;

  if (PE_COUNT < 1 || (PE_COUNT & (PE_COUNT - 1)) != 0) begin : g_pe_count_check
    $error("pe_addr_sequencer: PE_COUNT must be a power of two");
  end

  seq_state_t state;

  logic [DIM_W-1:0]  cfg_m, cfg_n, cfg_p;
  logic [CORE_W-1:0] cfg_core;
  logic              cfg_tr;
  logic [ADDR_W-1:0] cfg_lo, cfg_ro, cfg_reo;

  logic [TOT_W-1:0]  cells, cell0, cells_left;
  logic [DIM_W-1:0]  seek_row, seek_col;
  logic              seek_done;

  // Position of the beat currently presented on the outputs.
  logic [DIM_W-1:0]  k, col;
  logic [ADDR_W-1:0] kp, lbase, rbase, cell_idx;

  logic [DIM_W-1:0]  nxt_k, nxt_col, src_k;
  logic [ADDR_W-1:0] nxt_kp, nxt_lbase, nxt_rbase, nxt_cell;
  logic [ADDR_W-1:0] src_kp, src_lbase, src_rbase, src_cell;
  logic [ADDR_W-1:0] beat_left, beat_right, beat_result;
  logic              beat_first, beat_last, last_k, dim_zero;

  pe_partition #(
    .PE_COUNT (PE_COUNT),
    .DIM_W    (DIM_W),
    .CORE_W   (CORE_W)
  ) u_partition (
    .clk       (clk),
    .rst       (rst),
    .load      (state == ST_PART),
    .step      (state == ST_SEEK),
    .m         (cfg_m),
    .p         (cfg_p),
    .core_id   (cfg_core),
    .cells     (cells),
    .cell0     (cell0),
    .row       (seek_row),
    .col       (seek_col),
    .seek_done (seek_done)
  );

  assign busy     = (state != ST_IDLE) && (state != ST_DONE);
  assign dim_zero = (cfg_m == '0) || (cfg_n == '0) || (cfg_p == '0);
  assign last_k   = (k == cfg_n - DIM_W'(1));

  // Next beat position and the registered output values for the beat to present.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    nxt_k     = k + DIM_W'(1);
    nxt_kp    = kp + ADDR_W'(cfg_p);
    nxt_lbase = lbase;
    nxt_rbase = rbase;
    nxt_col   = col;
    nxt_cell  = cell_idx;
    if (last_k) begin
      nxt_k    = '0;
      nxt_kp   = '0;
      nxt_cell = cell_idx + ADDR_W'(1);
      if (col == cfg_p - DIM_W'(1)) begin
        nxt_col   = '0;
        nxt_lbase = lbase + ADDR_W'(cfg_n);
        nxt_rbase = '0;
      end else begin
        nxt_col   = col + DIM_W'(1);
        nxt_rbase = cfg_tr ? rbase + ADDR_W'(cfg_n) : rbase + ADDR_W'(1);
      end
    end
    // WAIT presents the position SEEK set up; RUN presents the one after a fire.
    src_k     = nxt_k;
    src_kp    = nxt_kp;
    src_lbase = nxt_lbase;
    src_rbase = nxt_rbase;
    src_cell  = nxt_cell;
    if (state == ST_WAIT) begin
      src_k     = k;
      src_kp    = kp;
      src_lbase = lbase;
      src_rbase = rbase;
      src_cell  = cell_idx;
    end
    beat_left   = cfg_lo + src_lbase + ADDR_W'(src_k);
    beat_right  = cfg_ro + (cfg_tr ? src_rbase + ADDR_W'(src_k) : src_kp + src_rbase);
    beat_result = cfg_reo + src_cell;
    beat_first  = (src_k == '0);
    beat_last   = (src_k == cfg_n - DIM_W'(1));
  end

  // Control FSM, latched job config, RUN counters and registered beat outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state here is plain registers (no arrays), so every one is reset.
    if (rst) begin
      state       <= ST_IDLE;
      cfg_m       <= '0;
      cfg_n       <= '0;
      cfg_p       <= '0;
      cfg_core    <= '0;
      cfg_tr      <= 1'b0;
      cfg_lo      <= '0;
      cfg_ro      <= '0;
      cfg_reo     <= '0;
      cells_left  <= '0;
      k           <= '0;
      kp          <= '0;
      col         <= '0;
      lbase       <= '0;
      rbase       <= '0;
      cell_idx    <= '0;
      addr_valid  <= 1'b0;
      left_addr   <= '0;
      right_addr  <= '0;
      result_addr <= '0;
      first       <= 1'b0;
      last        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cfg_m    <= M;
            cfg_n    <= N;
            cfg_p    <= P;
            cfg_core <= core_id;
            cfg_tr   <= right_transposed;
            cfg_lo   <= left_offset;
            cfg_ro   <= right_offset;
            cfg_reo  <= result_offset;
            done     <= 1'b0;
            err      <= 1'b0;
            state    <= ST_PART;
          end
        end
        ST_PART: begin
          cells_left <= cells;
          cell_idx   <= ADDR_W'(cell0);
          if (dim_zero) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (cells == '0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_SEEK;
          end
        end
        ST_SEEK: begin
          if (seek_done) begin
            k     <= '0;
            kp    <= '0;
            col   <= seek_col;
            lbase <= ADDR_W'(seek_row) * ADDR_W'(cfg_n);
            rbase <= cfg_tr ? ADDR_W'(seek_col) * ADDR_W'(cfg_n) : ADDR_W'(seek_col);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (data_ready) begin
            addr_valid  <= 1'b1;
            left_addr   <= beat_left;
            right_addr  <= beat_right;
            result_addr <= beat_result;
            first       <= beat_first;
            last        <= beat_last;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (addr_ready) begin
            if (last_k && cells_left == TOT_W'(1)) begin
              addr_valid <= 1'b0;
              first      <= 1'b0;
              last       <= 1'b0;
              done       <= 1'b1;
              state      <= ST_DONE;
            end else begin
              k           <= nxt_k;
              kp          <= nxt_kp;
              col         <= nxt_col;
              lbase       <= nxt_lbase;
              rbase       <= nxt_rbase;
              cell_idx    <= nxt_cell;
              left_addr   <= beat_left;
              right_addr  <= beat_right;
              result_addr <= beat_result;
              first       <= beat_first;
              last        <= beat_last;
              if (last_k) cells_left <= cells_left - TOT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_addr_sequencer.sv
// Testbench for pe_addr_sequencer: table-driven jobs on a 4-core and a 64-core
// instance, a scoreboard of golden beats, plus wait/reset/error sequences.
module tb_pe_addr_sequencer;
  import pe_pkg::*;

  typedef struct {
    core_cfg_t   cfg;
    int          core;
    bit          pe64;
    bit          stall;
    int          exp_beats;
    bit          exp_err;
    logic [31:0] exp_left;
    logic [31:0] exp_right;
    logic [31:0] exp_result;
  } vec_t;

  typedef struct {
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] result;
    logic        first;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start4, start64, data_ready, addr_ready, right_transposed;
  logic [15:0] m_in, n_in, p_in;
  logic [1:0]  core4;
  logic [5:0]  core64;
  logic [31:0] lo, ro, reo;

  logic        v4, f4, la4, busy4, done4, err4;
  logic [31:0] l4, r4, res4;
  logic        v64, f64, la64, busy64, done64, err64;
  logic [31:0] l64, r64, res64;

  logic        sel64;
  logic        s_valid, s_first, s_last, s_busy, s_done, s_err;
  logic [31:0] s_left, s_right, s_result;

  int   total = 0;
  int   bad   = 0;
  int   beats = 0;
  bit   mon_en = 1'b0;
  bit   prev_stall = 1'b0;
  logic [98:0] hold;
  beat_t sb[$];
  beat_t fb;
  bit    pat[4];
  vec_t  vecs[15];

  pe_addr_sequencer #(.PE_COUNT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .data_ready(data_ready),
    .M(m_in), .N(n_in), .P(p_in), .core_id(core4),
    .right_transposed(right_transposed),
    .left_offset(lo), .right_offset(ro), .result_offset(reo),
    .addr_valid(v4), .addr_ready(addr_ready),
    .left_addr(l4), .right_addr(r4), .first(f4), .last(la4),
    .result_addr(res4), .busy(busy4), .done(done4), .err(err4)
  );

  pe_addr_sequencer #(.PE_COUNT(64)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .data_ready(data_ready),
    .M(m_in), .N(n_in), .P(p_in), .core_id(core64),
    .right_transposed(right_transposed),
    .left_offset(lo), .right_offset(ro), .result_offset(reo),
    .addr_valid(v64), .addr_ready(addr_ready),
    .left_addr(l64), .right_addr(r64), .first(f64), .last(la64),
    .result_addr(res64), .busy(busy64), .done(done64), .err(err64)
  );

  // Observe whichever instance the current job targets.
  always_comb begin
    s_valid  = sel64 ? v64    : v4;
    s_first  = sel64 ? f64    : f4;
    s_last   = sel64 ? la64   : la4;
    s_busy   = sel64 ? busy64 : busy4;
    s_done   = sel64 ? done64 : done4;
    s_err    = sel64 ? err64  : err4;
    s_left   = sel64 ? l64    : l4;
    s_right  = sel64 ? r64    : r4;
    s_result = sel64 ? res64  : res4;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int m, input int n, input int p, input int core,
                              input bit tr, input bit pe64, input bit stall,
                              input logic [31:0] l_off, input logic [31:0] r_off,
                              input logic [31:0] res_off, input int nb, input bit e,
                              input logic [31:0] el, input logic [31:0] er,
                              input logic [31:0] eres);
    vec_t v;
    v.cfg.m = 16'(m);
    v.cfg.n = 16'(n);
    v.cfg.p = 16'(p);
    v.cfg.left_offset = l_off;
    v.cfg.right_offset = r_off;
    v.cfg.result_offset = res_off;
    v.cfg.right_transposed = tr;
    v.core = core;
    v.pe64 = pe64;
    v.stall = stall;
    v.exp_beats = nb;
    v.exp_err = e;
    v.exp_left = el;
    v.exp_right = er;
    v.exp_result = eres;
    return v;
  endfunction

  // Golden beat list straight from the matrix definition: cell c -> (c/P, c%P).
  task automatic build_sb(input vec_t v);
    longint pe, mm, nn, pp, tot, base, rem, core, cells, cell0, row, col;
    beat_t b;
    sb.delete();
    pe = v.pe64 ? 64 : 4;
    mm = v.cfg.m; nn = v.cfg.n; pp = v.cfg.p; core = v.core;
    tot = mm * pp;
    base = tot / pe;
    rem = tot % pe;
    cells = base + ((core < rem) ? 1 : 0);
    cell0 = core * base + ((core < rem) ? core : rem);
    if (mm == 0 || nn == 0 || pp == 0) cells = 0;
    for (longint c = cell0; c < cell0 + cells; c++) begin
      row = c / pp;
      col = c % pp;
      for (longint kk = 0; kk < nn; kk++) begin
        b.left = 32'(v.cfg.left_offset + row * nn + kk);
        b.right = v.cfg.right_transposed ? 32'(v.cfg.right_offset + col * nn + kk)
                                         : 32'(v.cfg.right_offset + kk * pp + col);
        b.result = 32'(v.cfg.result_offset + c);
        b.first = (kk == 0);
        b.last = (kk == nn - 1);
        sb.push_back(b);
      end
    end
  endtask

  task automatic set_cfg(input vec_t v);
    sel64 = v.pe64;
    m_in = v.cfg.m;
    n_in = v.cfg.n;
    p_in = v.cfg.p;
    lo = v.cfg.left_offset;
    ro = v.cfg.right_offset;
    reo = v.cfg.result_offset;
    right_transposed = v.cfg.right_transposed;
    core4 = 2'(v.core);
    core64 = 6'(v.core);
  endtask

  task automatic pulse_start(input bit pe64);
    @(posedge clk); #1;
    if (pe64) start64 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    start64 = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {v4, f4, la4, busy4, done4, err4}, 6'b0);
    check({tag, "_addr"}, {l4, r4, res4}, 96'b0);
  endtask

  // Wait for done with a cycle bound, driving the ready pattern; returns done seen.
  task automatic wait_done(input string tag, input bit stall, input int exp_beats);
    int  beats_prev;
    bit  seen;
    seen = 1'b0;
    for (int cyc = 0; cyc < 600 && !seen; cyc++) begin
      beats_prev = beats;
      @(posedge clk); #1;
      addr_ready = stall ? pat[cyc % 4] : 1'b1;
      if (s_done) begin
        seen = 1'b1;
        if (exp_beats > 0) check({tag, "_done_latency"}, beats_prev < beats, 1'b1);
      end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    build_sb(v);
    set_cfg(v);
    data_ready = 1'b1;
    addr_ready = 1'b1;
    beats = 0;
    prev_stall = 1'b0;
    mon_en = 1'b1;
    pulse_start(v.pe64);
    wait_done(tag, v.stall, v.exp_beats);
    mon_en = 1'b0;
    check({tag, "_beats"}, beats, v.exp_beats);
    check({tag, "_err"}, s_err, v.exp_err);
    check({tag, "_sb_left"}, sb.size(), 0);
    check({tag, "_idle_outs"}, {s_busy, s_valid}, 2'b00);
    if (v.exp_beats > 0)
      check({tag, "_first_beat"}, {fb.left, fb.right, fb.result, fb.first},
            {v.exp_left, v.exp_right, v.exp_result, 1'b1});
  endtask

  // Monitor: pops the scoreboard on every fire and checks stall stability.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_stall)
          check("stall_hold", {s_valid, s_first, s_last, s_left, s_right, s_result}, hold);
        prev_stall = s_valid && !addr_ready;
        hold = {s_valid, s_first, s_last, s_left, s_right, s_result};
        if (s_valid && addr_ready) begin
          check("sb_has_entry", sb.size() > 0, 1'b1);
          if (sb.size() > 0) begin
            b = sb.pop_front();
            check($sformatf("beat%0d", beats), {s_left, s_right, s_result, s_first, s_last},
                  {b.left, b.right, b.result, b.first, b.last});
            if (beats == 0) fb = b;
          end
          beats++;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    //              M  N  P  core tr pe64 stall lo            ro       reo           beats err left        right     result
    vecs[0]  = mk(4, 4, 4, 2, 0, 0, 0, 32'h0,        32'h0,   32'h0,        16, 0, 32'h8,       32'h0,   32'h8);
    vecs[1]  = mk(3, 2, 3, 1, 0, 0, 0, 32'h0,        32'h0,   32'h0,         4, 0, 32'h2,       32'h0,   32'h3);
    vecs[2]  = mk(4, 4, 4, 0, 1, 0, 0, 32'h0,        32'h0,   32'h0,        16, 0, 32'h0,       32'h0,   32'h0);
    vecs[3]  = mk(3, 2, 3, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,         6, 0, 32'h0,       32'h0,   32'h0);
    vecs[4]  = mk(0, 4, 4, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,         0, 1, 32'h0,       32'h0,   32'h0);
    vecs[5]  = mk(2, 3, 5, 3, 1, 0, 0, 32'h100,      32'h200, 32'h300,       6, 0, 32'h103,     32'h209, 32'h308);
    vecs[6]  = mk(2, 1, 2, 1, 0, 0, 0, 32'h0,        32'h0,   32'h0,         1, 0, 32'h0,       32'h1,   32'h1);
    vecs[7]  = mk(4, 4, 4, 3, 0, 0, 0, 32'hFFFFFFFE, 32'h0,   32'hFFFFFFFF, 16, 0, 32'hA,       32'h0,   32'hB);
    vecs[8]  = mk(3, 2, 3, 3, 0, 0, 0, 32'h0,        32'h0,   32'h0,         4, 0, 32'h4,       32'h1,   32'h7);
    vecs[9]  = mk(4, 4, 4, 2, 0, 0, 1, 32'h0,        32'h0,   32'h0,        16, 0, 32'h8,       32'h0,   32'h8);
    vecs[10] = mk(2, 3, 2, 10, 0, 1, 0, 32'h0,       32'h0,   32'h0,         0, 0, 32'h0,       32'h0,   32'h0);
    vecs[11] = mk(2, 3, 2, 2, 0, 1, 0, 32'h0,        32'h0,   32'h0,         3, 0, 32'h3,       32'h0,   32'h2);
    vecs[12] = mk(4, 4, 4, 1, 1, 0, 1, 32'h0,        32'h0,   32'h0,        16, 0, 32'h4,       32'h0,   32'h4);
    vecs[13] = mk(2, 2, 0, 0, 0, 1, 0, 32'h0,        32'h0,   32'h0,         0, 1, 32'h0,       32'h0,   32'h0);
    vecs[14] = mk(5, 3, 3, 0, 1, 0, 1, 32'h40,       32'h80,  32'h10,       12, 0, 32'h40,      32'h80,  32'h10);

    rst = 1'b1; start4 = 1'b0; start64 = 1'b0; data_ready = 1'b0; addr_ready = 1'b1;
    sel64 = 1'b0;
    set_cfg(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Zero dimension: err and done within two cycles of start, no beats.
    set_cfg(vecs[4]);
    sb.delete();
    beats = 0;
    prev_stall = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1;
    check("zero_dim_done_err", {s_done, s_err}, 2'b11);
    mon_en = 1'b0;

    // WAIT holds until data_ready; start clears err/done; busy one cycle after start.
    build_sb(vecs[0]);
    set_cfg(vecs[0]);
    data_ready = 1'b0;
    addr_ready = 1'b1;
    beats = 0;
    prev_stall = 1'b0;
    mon_en = 1'b1;
    pulse_start(1'b0);
    check("start_busy_clear", {s_busy, s_done, s_err}, 3'b100);
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      saw_valid = saw_valid | s_valid;
    end
    check("wait_no_valid", saw_valid, 1'b0);
    data_ready = 1'b1;
    @(posedge clk); #1;
    check("wait_release", {s_valid, s_first, s_left, s_result}, {1'b1, 1'b1, 32'h8, 32'h8});
    wait_done("wait_seq", 1'b0, 16);
    mon_en = 1'b0;
    check("wait_seq_beats", beats, 16);

    // Reset in the middle of RUN, then a fresh run from k=0.
    build_sb(vecs[0]);
    set_cfg(vecs[0]);
    data_ready = 1'b1;
    beats = 0;
    prev_stall = 1'b0;
    mon_en = 1'b1;
    pulse_start(1'b0);
    repeat (7) @(posedge clk);
    #1;
    check("mid_run_active", s_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    mon_en = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec(vecs[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_addr_sequencer.md
# pe_addr_sequencer

Parametrised per-core operand/result address sequencer for the matrix-multiply PE array. Each core partitions the M×P output among `PE_COUNT` cores, including non-divisible remainders. It then streams (left, right) operand address pairs to its PE over a valid/ready handshake, one per multiply-accumulate step, and tags the first and last step of every output cell with the result address. It sits between the AXI load/control registers and one PE datapath, one instance per core, and supports row-major or pre-transposed right operands.

## Interface
- `PE_COUNT`, 64, number of cores; power of two, ≥1 (elaboration error otherwise)
- `DIM_W`, 16, width of M, N, P
- `ADDR_W`, 32, width of all addresses and offsets
- `CORE_W`, $clog2(PE_COUNT) (min 1), width of core_id

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; asynchronous and active-high
- `start`  in  1  pulse: latch config, begin partitioning
- `data_ready`  in  1  level: all operand data resident in memory
- `M`, `N`, `P`  in  DIM_W  each: left is M×N, right is N×P
- `core_id`  in  CORE_W  this core's index
- `right_transposed`  in  1  0: right row-major N×P; 1: stored P×N
- `left_offset`, `right_offset`, `result_offset`  in  ADDR_W  each: base addresses
- `addr_valid`  out  1  operand pair valid
- `addr_ready`  in  1  PE accepts pair
- `left_addr`, `right_addr`  out  ADDR_W  each: operand addresses
- `first`  out  1  beat is k=0: clear accumulator
- `last`  out  1  beat is k=N-1: write accumulator to `result_addr`
- `result_addr`  out  ADDR_W  result_offset + current cell index
- `busy`  out  1  not IDLE/DONE
- `done`  out  1  level, all cells issued; cleared by next start
- `err`  out  1  level, M, N or P zero at start; cleared by next start

## Operation
- States: IDLE, PART, SEEK, WAIT, RUN, DONE.
- IDLE/DONE + `start` → PART. Latch M, N, P, core_id, mode, offsets. Clear done/err. `start` is ignored in other states.
- PART (1 cycle):
  - total = M·P (2·DIM_W bits), base = total >> log2(PE_COUNT), rem = total & (PE_COUNT−1).
  - cells = base + (core_id < rem); cell0 = core_id·base + min(core_id, rem).
  - If any dim is 0: err=1 → DONE. Else if cells=0 → DONE. Else col=cell0, row=0 → SEEK.
- SEEK: per cycle, while col ≥ P: col −= P, row += 1. When col < P → WAIT. Then precompute lbase = row·N, rbase = transposed ? col·N : col.
- WAIT: `data_ready` → RUN. Data_ready sampled as level.
- RUN: k from 0 to N−1.
  - left_addr = left_offset + lbase + k.
  - right_addr = right_offset + (transposed ? rbase + k : k·P + rbase).
  - k·P is kept as an incremental accumulator, not a multiplier.
  - A beat fires on `addr_valid && addr_ready`; k advances only on a fire.
  - Fire with k=N−1: cell+1, cells_left−1, col+1. If col+1 = P: col=0, lbase += N, rbase reset. Then k=0.
  - Final cell's last fire → DONE.
- All address arithmetic wraps modulo 2^ADDR_W. No overflow flag.
- N=1: every beat has first=last=1.

## Timing
- Reset values: addr_valid=0, first=0, last=0, busy=0, done=0, err=0, left/right/result_addr=0; state IDLE.
- `rst` mid-operation aborts immediately. No partial-cell completion.
- start → busy: 1 cycle. PART is 1 cycle. SEEK is (row0+1) cycles, where row0 = cell0 / P.
- WAIT → first addr_valid: the cycle after `data_ready` is seen high.
- In RUN, addr_valid stays high continuously; one beat per cycle while addr_ready=1. Throughput is 1 MAC/cycle.
- While addr_valid && !addr_ready, all outputs hold stable.
- first, last and result_addr are registered and coincident with their beat.
- done rises the cycle after the final fire. busy falls the same cycle.
- `start` in the same cycle as done rising is ignored.

## Structure
- Shared package `pe_pkg`: state enum `seq_state_t`, `DIM_W`/`ADDR_W` defaults, a `core_cfg_t` struct (dims, offsets, mode).
- Sub-module `pe_partition`: PART-stage arithmetic (cells, cell0) plus the SEEK loop. Reusable by the result-collection side.

## Test plan
- PE_COUNT=4, M=N=P=4, core 2, row-major, ready=1: cells=4, cell0=8. Pairs (8,0),(9,4),(10,8),(11,12) for the first cell. result_addr=8. first/last on beats 0/3.
- PE_COUNT=4, M=3, P=3, N=2: total=9 → cores get 3,2,2,2 cells. Core 1 cell0=3 → row 1, col 0. Check done after 4 beats.
- Same as scenario 1 with right_transposed=1: right_addr = col·N + k. For core 0 cell 1, expect 4,5,6,7.
- Backpressure: addr_ready toggles 1,0,0,1 mid-cell. Outputs hold stable during stalls; the beat count equals cells·N exactly.
- M=0 at start → err=1, done=1 within 2 cycles, never addr_valid. PE_COUNT=64, M=P=2: core 10 → cells=0, done without beats.
- Assert rst during RUN, then start again → all outputs at reset values. The fresh run matches the golden address list from k=0.
